reward_scheduler: RTL and testbench

//   Lifecycle controller for the on-field reward icon drawn by the reward renderer.

---
 rtl/reward_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_reward_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reward_scheduler.sv
// Reward lifecycle controller: waits, picks a random legal grid cell and type,
// shows the reward until pickup or expiry, then holds the power-up effect.
module reward_scheduler #(
  parameter int          TICK_DIV     = 100000,
  parameter int          SPAWN_TICKS  = 5000,
  parameter int          LIFE_TICKS   = 8000,
  parameter int          EFFECT_TICKS = 10000,
  parameter int          GRID_X_MAX   = 26,
  parameter int          GRID_Y_MAX   = 18,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_game_classic,
  input  logic       enable_game_infinity,
  input  logic       tank_valid,
  input  logic [4:0] tank_xpos,
  input  logic [4:0] tank_ypos,
  output logic       set_require,
  output logic [4:0] random_xpos,
  output logic [4:0] random_ypos,
  output logic [2:0] reward_type,
  output logic       effect_valid,
  output logic [2:0] effect_type,
  output logic       add_time_pulse
);

  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_SL = (SPAWN_TICKS > LIFE_TICKS) ? SPAWN_TICKS : LIFE_TICKS;
  localparam int MAX_T  = (MAX_SL > EFFECT_TICKS) ? MAX_SL : EFFECT_TICKS;
  localparam int TW     = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PICK, S_SHOW, S_EFFECT} state_t;

  state_t      state, state_nxt;
  logic [PW-1:0] presc;
  logic [TW-1:0] timer;
  logic [5:0]  rej_cnt;
  logic [15:0] lfsr;

  logic       game_on, infinity_only, tick, hit, cand_ok;
  logic       spawn_done, life_done, effect_done;
  logic [4:0] cand_x, cand_y, force_x;
  logic [2:0] cand_t;

  logic       set_nxt, ev_nxt, pulse_nxt;
  logic [4:0] x_nxt, y_nxt;
  logic [2:0] t_nxt, et_nxt;

  assign game_on       = enable_game_classic | enable_game_infinity;
  assign infinity_only = enable_game_infinity & ~enable_game_classic;

  assign tick        = (presc == PW'(TICK_DIV - 1));
  assign spawn_done  = tick && (timer == TW'(SPAWN_TICKS - 1));
  assign life_done   = tick && (timer == TW'(LIFE_TICKS - 1));
  assign effect_done = tick && (timer == TW'(EFFECT_TICKS - 1));

  assign cand_x  = lfsr[4:0];
  assign cand_y  = lfsr[9:5];
  assign cand_t  = lfsr[12:10];
  assign cand_ok = (cand_x <= 5'(GRID_X_MAX)) && (cand_y <= 5'(GRID_Y_MAX)) &&
                   (cand_t >= 3'd1) && (cand_t <= 3'd4);
  // A 5-bit column never exceeds twice the grid width, so one subtract is a full modulo.
  assign force_x = (cand_x > 5'(GRID_X_MAX)) ? cand_x - 5'(GRID_X_MAX + 1) : cand_x;

  assign hit = tank_valid && (tank_xpos == random_xpos) && (tank_ypos == random_ypos);

  // Next-state and next-output decode; outputs are registered so they change one cycle after the decision.
  always_comb begin
    state_nxt = state;
    set_nxt   = 1'b0;
    x_nxt     = random_xpos;
    y_nxt     = random_ypos;
    t_nxt     = reward_type;
    ev_nxt    = effect_valid;
    et_nxt    = effect_type;
    pulse_nxt = 1'b0;
    if (!game_on) begin
      state_nxt = S_IDLE;
      x_nxt     = '0;
      y_nxt     = '0;
      t_nxt     = '0;
      ev_nxt    = 1'b0;
      et_nxt    = '0;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_WAIT;
        S_WAIT: if (spawn_done) state_nxt = S_PICK;
        S_PICK: begin
          if (cand_ok) begin
            x_nxt     = cand_x;
            y_nxt     = cand_y;
            t_nxt     = cand_t;
            set_nxt   = 1'b1;
            state_nxt = S_SHOW;
          end else if (rej_cnt == 6'd32) begin
            x_nxt     = force_x;
            y_nxt     = 5'(GRID_Y_MAX / 2);
            t_nxt     = 3'd1;
            set_nxt   = 1'b1;
            state_nxt = S_SHOW;
          end
        end
        S_SHOW: begin
          set_nxt = 1'b1;
          if (hit) begin
            set_nxt = 1'b0;
            if (infinity_only && (reward_type == 3'd1)) begin
              pulse_nxt = 1'b1;
              state_nxt = S_WAIT;
            end else begin
              ev_nxt    = 1'b1;
              et_nxt    = reward_type;
              state_nxt = S_EFFECT;
            end
          end else if (life_done) begin
            set_nxt   = 1'b0;
            state_nxt = S_WAIT;
          end
        end
        S_EFFECT: begin
          if (effect_done) begin
            ev_nxt    = 1'b0;
            et_nxt    = '0;
            state_nxt = S_WAIT;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register together with the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      set_require    <= 1'b0;
      random_xpos    <= '0;
      random_ypos    <= '0;
      reward_type    <= '0;
      effect_valid   <= 1'b0;
      effect_type    <= '0;
      add_time_pulse <= 1'b0;
    end else begin
      state          <= state_nxt;
      set_require    <= set_nxt;
      random_xpos    <= x_nxt;
      random_ypos    <= y_nxt;
      reward_type    <= t_nxt;
      effect_valid   <= ev_nxt;
      effect_type    <= et_nxt;
      add_time_pulse <= pulse_nxt;
    end
  end

  // Tick prescaler, tick timer and reject counter, all restarted whenever the state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      timer   <= '0;
      rej_cnt <= '0;
    end else if (state_nxt != state) begin
      presc   <= '0;
      timer   <= '0;
      rej_cnt <= '0;
    end else begin
      if (tick) begin
        presc <= '0;
        timer <= timer + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if ((state == S_PICK) && !cand_ok && (rej_cnt != 6'd32))
        rej_cnt <= rej_cnt + 1'b1;
    end
  end

  // Free-running Fibonacci LFSR, taps 16/14/13/11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

endmodule

// File: tb/tb_reward_scheduler.sv
// Scoreboard bench for reward_scheduler: stimulus queues expected output events,
// a negedge monitor detects edges on the outputs and checks them against the queue.
module tb_reward_scheduler;

  localparam int          TICK_DIV     = 4;
  localparam int          SPAWN_TICKS  = 3;
  localparam int          LIFE_TICKS   = 5;
  localparam int          EFFECT_TICKS = 4;
  localparam int          WAIT_CYC     = 12;
  localparam int          LIFE_CYC     = 20;
  localparam int          EFFECT_CYC   = 16;
  localparam int          PICK_MAX     = 33;
  localparam logic [15:0] SEED         = 16'hACE1;

  logic       clk, rst_n;
  logic       enable_game_classic, enable_game_infinity, tank_valid;
  logic [4:0] tank_xpos, tank_ypos, random_xpos, random_ypos;
  logic       set_require, effect_valid, add_time_pulse;
  logic [2:0] reward_type, effect_type;

  typedef enum {EV_RISE, EV_FALL, EV_EFF_RISE, EV_EFF_FALL, EV_PULSE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       lo;
    int       hi;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  logic [15:0] m_lfsr, m_prev;
  logic [4:0]  pred_x, pred_y;
  logic [2:0]  pred_t;

  bit p_set = 0, p_eff = 0, p_pulse = 0;
  int low_cnt = 0, high_cnt = 0, eff_cnt = 0, pulse_cnt = 0;

  reward_scheduler #(
    .TICK_DIV(TICK_DIV), .SPAWN_TICKS(SPAWN_TICKS), .LIFE_TICKS(LIFE_TICKS),
    .EFFECT_TICKS(EFFECT_TICKS), .GRID_X_MAX(26), .GRID_Y_MAX(18), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .enable_game_classic(enable_game_classic), .enable_game_infinity(enable_game_infinity),
    .tank_valid(tank_valid), .tank_xpos(tank_xpos), .tank_ypos(tank_ypos),
    .set_require(set_require), .random_xpos(random_xpos), .random_ypos(random_ypos),
    .reward_type(reward_type), .effect_valid(effect_valid), .effect_type(effect_type),
    .add_time_pulse(add_time_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int allOutputs();
    return int'({set_require, random_xpos, random_ypos, reward_type,
                 effect_valid, effect_type, add_time_pulse});
  endfunction

  // Reference LFSR; m_prev holds the value seen during the cycle before the latest edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsrStep(m_lfsr);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: got timeout, expected event within bound", name);
  endtask

  task automatic pushExp(input ev_kind_t k, input int lo, input int hi);
    ev_t e;
    e.kind = k;
    e.lo   = lo;
    e.hi   = hi;
    exp_q.push_back(e);
  endtask

  task automatic report(input ev_kind_t k, input int val);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL unexpected_event: got %s=%0d, expected no event", k.name(), val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || val < e.lo || val > e.hi) begin
        n_fail++;
        $display("[TB] FAIL event_%s: got %s=%0d, expected %s in %0d..%0d",
                 e.kind.name(), k.name(), val, e.kind.name(), e.lo, e.hi);
      end
    end
  endtask

  // Predicts the shown reward from the LFSR value present in the accepting PICK cycle.
  task automatic predictReward();
    logic [4:0] cx, cy;
    logic [2:0] ct;
    cx = m_prev[4:0];
    cy = m_prev[9:5];
    ct = m_prev[12:10];
    if (cx <= 5'd26 && cy <= 5'd18 && ct >= 3'd1 && ct <= 3'd4) begin
      pred_x = cx;
      pred_y = cy;
      pred_t = ct;
    end else begin
      pred_x = (cx > 5'd26) ? cx - 5'd27 : cx;
      pred_y = 5'd9;
      pred_t = 3'd1;
    end
  endtask

  task automatic applyStimulus(input bit classic, input bit infinity);
    enable_game_classic  = classic;
    enable_game_infinity = infinity;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Returns one time unit after the first sample where set_require is seen rising.
  task automatic waitRise(output bit ok);
    bit was;
    was = set_require;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!was && set_require) begin
        ok = 1'b1;
        break;
      end
      was = set_require;
    end
    if (!ok) failNow("set_require_rise");
  endtask

  // Drives the tank onto the predicted reward cell for exactly one cycle.
  task automatic pickupNow();
    tank_valid = 1'b1;
    tank_xpos  = pred_x;
    tank_ypos  = pred_y;
    @(negedge clk);
    #1;
    tank_valid = 1'b0;
  endtask

  // Monitor: turns output edges into events and checks each against the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (p_set && !set_require)        report(EV_FALL, high_cnt);
      if (!p_eff && effect_valid)       report(EV_EFF_RISE, int'(effect_type));
      if (p_pulse && !add_time_pulse)   report(EV_PULSE, pulse_cnt);
      if (p_eff && !effect_valid)       report(EV_EFF_FALL, eff_cnt);
      if (!p_set && set_require) begin
        report(EV_RISE, low_cnt);
        predictReward();
        checkOutput("reward_position", int'({random_xpos, random_ypos, reward_type}),
                    int'({pred_x, pred_y, pred_t}));
      end
      high_cnt  = set_require ? high_cnt + 1 : 0;
      low_cnt   = set_require ? 0 : low_cnt + 1;
      if (!rst_n) low_cnt = 0;
      eff_cnt   = effect_valid ? eff_cnt + 1 : 0;
      pulse_cnt = add_time_pulse ? pulse_cnt + 1 : 0;
      p_set     = set_require;
      p_eff     = effect_valid;
      p_pulse   = add_time_pulse;
    end
  end

  // Directed stimulus sequence.
  initial begin : stimulus
    bit ok, found;
    int gap_lo;
    rst_n      = 1'b0;
    tank_valid = 1'b0;
    tank_xpos  = '0;
    tank_ypos  = '0;
    applyStimulus(1'b0, 1'b0);
    waitCycles(3);
    checkOutput("reset_outputs", allOutputs(), 0);

    applyStimulus(1'b1, 1'b0);
    pushExp(EV_RISE, WAIT_CYC + 1, WAIT_CYC + PICK_MAX);
    rst_n = 1'b1;
    waitRise(ok);

    pushExp(EV_FALL, 1, 1);
    pushExp(EV_EFF_RISE, int'(pred_t), int'(pred_t));
    pushExp(EV_EFF_FALL, EFFECT_CYC, EFFECT_CYC);
    pickupNow();
    checkOutput("pickup_latency", int'({set_require, effect_valid}), 1);

    pushExp(EV_RISE, EFFECT_CYC + WAIT_CYC + 1, EFFECT_CYC + WAIT_CYC + PICK_MAX);
    waitRise(ok);
    pushExp(EV_FALL, LIFE_CYC, LIFE_CYC);

    pushExp(EV_RISE, WAIT_CYC + 1, WAIT_CYC + PICK_MAX);
    waitRise(ok);
    pushExp(EV_FALL, LIFE_CYC, LIFE_CYC);
    pushExp(EV_EFF_RISE, int'(pred_t), int'(pred_t));
    pushExp(EV_EFF_FALL, EFFECT_CYC, EFFECT_CYC);
    waitCycles(LIFE_CYC - 1);
    pickupNow();
    checkOutput("pickup_at_expiry", int'({set_require, effect_valid}), 1);

    applyStimulus(1'b0, 1'b1);
    gap_lo = EFFECT_CYC + WAIT_CYC + 1;
    found  = 1'b0;
    for (int r = 0; r < 40 && !found; r++) begin
      pushExp(EV_RISE, gap_lo, gap_lo + PICK_MAX - 1);
      waitRise(ok);
      if (!ok) break;
      if (pred_t == 3'd1) begin
        pushExp(EV_FALL, 1, 1);
        pushExp(EV_PULSE, 1, 1);
        pickupNow();
        checkOutput("pulse_without_effect",
                    int'({add_time_pulse, effect_valid, set_require}), 4);
        found = 1'b1;
      end else begin
        pushExp(EV_FALL, LIFE_CYC, LIFE_CYC);
        gap_lo = WAIT_CYC + 1;
      end
    end
    if (!found) failNow("infinity_type1_pickup");

    pushExp(EV_RISE, WAIT_CYC + 1, WAIT_CYC + PICK_MAX);
    waitRise(ok);
    pushExp(EV_FALL, 4, 4);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0);
    waitCycles(1);
    checkOutput("mode_drop_clear", allOutputs(), 0);
    waitCycles(2);
    pushExp(EV_RISE, WAIT_CYC + 4, WAIT_CYC + 3 + PICK_MAX);
    applyStimulus(1'b1, 1'b0);
    waitRise(ok);

    pushExp(EV_FALL, 1, 1);
    pushExp(EV_EFF_RISE, int'(pred_t), int'(pred_t));
    pushExp(EV_EFF_FALL, 5, 5);
    pickupNow();
    waitCycles(4);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_clear", allOutputs(), 0);
    pushExp(EV_RISE, WAIT_CYC + 1, WAIT_CYC + PICK_MAX);
    waitCycles(2);
    rst_n = 1'b1;
    waitRise(ok);

    pushExp(EV_FALL, 1, 1);
    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("events_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
